cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle instruction sequencer that drives every control input of the 8-bit processor datapath (register file, ALU, shifter, PC, LIFO) from a 16-bit instruction word.
- Runs a FETCH/DECODE/EXECUTE state machine, resolves conditional branches from the registered datapath flags, and issues single-cycle I/O port strobes.
- Sits between program ROM, datapath and I/O bus.

Parameters:
- ALU_PASS, 3'b000, opalu code for which the ALU output equals portA. Used by OUT and SH.
- ADDR_W, 11, instruction address width. Must match the datapath PC.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- instruction  in  16  ROM word for current inst_addr; valid in DECODE
- zero, carry  in  1 each  registered flags from datapath
- stack_addr  in  ADDR_W  top-of-stack + 1 from datapath
- io_ready  in  1  I/O device ready; used only with CU_IO_WAIT_EN
- insel, we, selk, selimm, selpc, ldpc, ldflag, wr_en, rd_en  out  1 each  datapath controls
- raa, rab, wa  out  3 each  register addresses
- opalu, sh  out  3 each  ALU op, shifter op
- kte, imm  out  8 each  constant/immediate = ir[7:0]
- ninst_addr  out  ADDR_W  jump target
- port_addr  out  8  I/O port number = ir[7:0]
- rd_strobe, wr_strobe  out  1 each  I/O read/write strobe
- halted  out  1  high in HALT state

Behaviour:
- Encoding: op = ir[15:11], ra = ir[10:8], rb = ir[7:5], k = ir[7:0], target = ir[10:0].
- States: FETCH -> DECODE -> EXECUTE -> FETCH. HALT is absorbing.
- ir is loaded from instruction on the DECODE clock edge.
- Outputs are combinational from state and ir. All outputs are 0 in FETCH, DECODE, HALT and reset. Exception: halted=1 in HALT.
- EXECUTE always asserts ldpc=1, selpc=0 (PC+1), unless a branch is taken.
- 00001 LDI: wa=ra, selk=1, insel=0, we=1.
- 00010 IN: wa=ra, selk=0, insel=0, we=1, rd_strobe=1.
- 00011 OUT: raa=ra, opalu=ALU_PASS, selimm=0, wr_strobe=1.
- 01ooo ALU reg: raa=wa=ra, rab=rb, opalu=ooo, selimm=0, insel=1, we=1, ldflag=1, sh=0.
- 10ooo ALU imm: as ALU reg, but selimm=1.
- 11000 SH: raa=wa=ra, opalu=ALU_PASS, sh=ir[2:0], insel=1, we=1, ldflag=1.
- 11001 JMP: selpc=1, ninst_addr=target.
- 11010 JZ: same as JMP only if zero=1; otherwise PC+1.
- 11011 JC: same as JMP only if carry=1; otherwise PC+1.
- 11100 CALL: wr_en=1 (pushes current PC), selpc=1, ninst_addr=target.
- 11101 RET: rd_en=1, selpc=1, ninst_addr=stack_addr.
- 11110 HALT: ldpc=0, next state HALT. Only rst exits HALT.
- 00000, 00100-00111, 11111: NOP, PC+1 only.
- Branch conditions sample the flags in EXECUTE. Flags updated by the previous instruction's EXECUTE are visible.
- Strobes are exactly one cycle per instruction. we and ldflag are never asserted outside EXECUTE.
- Stack overflow/underflow is not detected; the datapath LIFO behaviour governs.
- rst low at any time: state forced to FETCH, ir cleared, outputs 0 asynchronously. Execution resumes from PC=0 after release.

Optional Feature:
- CU_IO_WAIT_EN.
- Defined: IN/OUT remain in EXECUTE with rd_strobe/wr_strobe held high until io_ready=1.
  - we and ldpc are asserted only in the io_ready=1 cycle, then the FSM proceeds to FETCH.
  - rst aborts the wait.
- Undefined: IN/OUT complete in one EXECUTE cycle and io_ready is ignored.

Test Plan:
- Reset: rst=0 mid-EXECUTE of an ALU op -> all outputs 0 immediately. After release, the first FETCH has ldpc=0, and EXECUTE of 0x0000 gives PC 0->1.
- LDI r3,0x5A (0x0B5A) -> one EXECUTE cycle with wa=3, selk=1, insel=0, we=1, kte=0x5A, ldpc=1, selpc=0. Exactly 3 cycles per instruction.
- ALU imm, op=3'b001, r2, k=0x0F (0x8A0F) -> raa=wa=2, opalu=001, selimm=1, imm=0x0F, insel=1, we=1, ldflag=1.
- JZ 0x123 (0xD123):
  - with zero=1 -> selpc=1, ninst_addr=0x123.
  - with zero=0 -> selpc=0, ldpc=1.
  - JC 0x123 (0xD923) with carry=1 -> taken.
- CALL 0x040 at PC=0x010 -> wr_en=1 one cycle, ninst_addr=0x040. Subsequent RET with stack_addr=0x011 -> rd_en=1, ninst_addr=0x011.
- HALT (0xF000) -> halted=1, ldpc=0 forever. With CU_IO_WAIT_EN, IN r1,0x20 with io_ready low 4 cycles -> rd_strobe high 5 cycles and we only in the last cycle.

Source files
------------

// File: rtl/cpu_sequencer.sv
// FETCH/DECODE/EXECUTE sequencer for the 8-bit datapath; outputs are decoded combinationally from state and ir.
// Optional macro CU_IO_WAIT_EN: IN/OUT hold EXECUTE with strobes high until io_ready.
module cpu_sequencer #(
  parameter logic [2:0] ALU_PASS = 3'b000,
  parameter int         ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instruction,
  input  logic              zero,
  input  logic              carry,
  input  logic [ADDR_W-1:0] stack_addr,
  input  logic              io_ready,
  output logic              insel,
  output logic              we,
  output logic              selk,
  output logic              selimm,
  output logic              selpc,
  output logic              ldpc,
  output logic              ldflag,
  output logic              wr_en,
  output logic              rd_en,
  output logic [2:0]        raa,
  output logic [2:0]        rab,
  output logic [2:0]        wa,
  output logic [2:0]        opalu,
  output logic [2:0]        sh,
  output logic [7:0]        kte,
  output logic [7:0]        imm,
  output logic [ADDR_W-1:0] ninst_addr,
  output logic [7:0]        port_addr,
  output logic              rd_strobe,
  output logic              wr_strobe,
  output logic              halted
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [4:0]  op;
  logic [2:0]  ra, rb;
  logic        io_done;
  logic        is_io;

  assign op    = ir_q[15:11];
  assign ra    = ir_q[10:8];
  assign rb    = ir_q[7:5];
  assign is_io = (op == 5'b00010) || (op == 5'b00011);

`ifdef CU_IO_WAIT_EN
  assign io_done = io_ready;
`else
  logic unused_io_ready;
  assign unused_io_ready = io_ready;
  assign io_done = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_EXEC;
        ir_d    = instruction;
      end
      S_EXEC: begin
        if (op == 5'b11110)       state_d = S_HALT;
        else if (is_io && !io_done) state_d = S_EXEC;
        else                      state_d = S_FETCH;
      end
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    insel = 1'b0; we = 1'b0; selk = 1'b0; selimm = 1'b0; selpc = 1'b0;
    ldpc = 1'b0; ldflag = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    raa = '0; rab = '0; wa = '0; opalu = '0; sh = '0;
    kte = '0; imm = '0; ninst_addr = '0; port_addr = '0;
    rd_strobe = 1'b0; wr_strobe = 1'b0;
    halted = (state_q == S_HALT);
    if (state_q == S_EXEC) begin
      kte       = ir_q[7:0];
      imm       = ir_q[7:0];
      port_addr = ir_q[7:0];
      ldpc      = 1'b1;
      casez (op)
        5'b00001: begin wa = ra; selk = 1'b1; we = 1'b1; end
        5'b00010: begin
          wa = ra; rd_strobe = 1'b1; we = io_done; ldpc = io_done;
        end
        5'b00011: begin
          raa = ra; opalu = ALU_PASS; wr_strobe = 1'b1; ldpc = io_done;
        end
        5'b01???, 5'b10???: begin
          raa = ra; wa = ra; rab = rb; opalu = op[2:0];
          selimm = op[4]; insel = 1'b1; we = 1'b1; ldflag = 1'b1;
        end
        5'b11000: begin
          raa = ra; wa = ra; opalu = ALU_PASS; sh = ir_q[2:0];
          insel = 1'b1; we = 1'b1; ldflag = 1'b1;
        end
        // Conditional branches fall through to PC+1 when their flag is clear.
        5'b11001, 5'b11010, 5'b11011: begin
          if (op == 5'b11001 || (op == 5'b11010 && zero) || (op == 5'b11011 && carry)) begin
            selpc      = 1'b1;
            ninst_addr = ADDR_W'(ir_q[10:0]);
          end
        end
        5'b11100: begin
          wr_en = 1'b1; selpc = 1'b1; ninst_addr = ADDR_W'(ir_q[10:0]);
        end
        5'b11101: begin
          rd_en = 1'b1; selpc = 1'b1; ninst_addr = stack_addr;
        end
        5'b11110: ldpc = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomised self-checking bench for cpu_sequencer against an instruction-level reference model.
module tb_cpu_sequencer;

  typedef struct packed {
    logic        insel, we, selk, selimm, selpc, ldpc, ldflag, wr_en, rd_en;
    logic [2:0]  raa, rab, wa, opalu, sh;
    logic [7:0]  kte, imm;
    logic [10:0] ninst_addr;
    logic [7:0]  port_addr;
    logic        rd_strobe, wr_strobe, halted;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instruction = '0;
  logic        zero = 1'b0, carry = 1'b0, io_ready = 1'b1;
  logic [10:0] stack_addr = '0;
  out_t        obs;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .carry(carry),
    .stack_addr(stack_addr), .io_ready(io_ready),
    .insel(obs.insel), .we(obs.we), .selk(obs.selk), .selimm(obs.selimm),
    .selpc(obs.selpc), .ldpc(obs.ldpc), .ldflag(obs.ldflag), .wr_en(obs.wr_en),
    .rd_en(obs.rd_en), .raa(obs.raa), .rab(obs.rab), .wa(obs.wa), .opalu(obs.opalu),
    .sh(obs.sh), .kte(obs.kte), .imm(obs.imm), .ninst_addr(obs.ninst_addr),
    .port_addr(obs.port_addr), .rd_strobe(obs.rd_strobe), .wr_strobe(obs.wr_strobe),
    .halted(obs.halted)
  );

  // Expected EXECUTE-cycle controls for one instruction, from the instruction-set table.
  function automatic out_t model(input logic [15:0] ins, input logic z, input logic c,
                                 input logic [10:0] sa, input logic rdy);
    out_t e;
    logic [4:0] op;
    logic       done;
    op = ins[15:11];
`ifdef CU_IO_WAIT_EN
    done = rdy;
`else
    done = 1'b1;
`endif
    e = '0;
    e.kte = ins[7:0]; e.imm = ins[7:0]; e.port_addr = ins[7:0];
    e.ldpc = 1'b1;
    if (op == 5'd1) begin
      e.wa = ins[10:8]; e.selk = 1'b1; e.we = 1'b1;
    end else if (op == 5'd2) begin
      e.wa = ins[10:8]; e.rd_strobe = 1'b1; e.we = done; e.ldpc = done;
    end else if (op == 5'd3) begin
      e.raa = ins[10:8]; e.wr_strobe = 1'b1; e.ldpc = done;
    end else if (op >= 5'd8 && op <= 5'd23) begin
      e.raa = ins[10:8]; e.wa = ins[10:8]; e.rab = ins[7:5]; e.opalu = ins[13:11];
      e.selimm = (op >= 5'd16); e.insel = 1'b1; e.we = 1'b1; e.ldflag = 1'b1;
    end else if (op == 5'd24) begin
      e.raa = ins[10:8]; e.wa = ins[10:8]; e.sh = ins[2:0];
      e.insel = 1'b1; e.we = 1'b1; e.ldflag = 1'b1;
    end else if (op == 5'd25 || (op == 5'd26 && z) || (op == 5'd27 && c) || op == 5'd28) begin
      e.selpc = 1'b1; e.ninst_addr = ins[10:0]; e.wr_en = (op == 5'd28);
    end else if (op == 5'd29) begin
      e.rd_en = 1'b1; e.selpc = 1'b1; e.ninst_addr = sa;
    end else if (op == 5'd30) begin
      e.ldpc = 1'b0;
    end
    return e;
  endfunction

  // Starts and ends at a negedge in FETCH; checks FETCH, DECODE and the single EXECUTE cycle.
  task automatic run_instr(input logic [15:0] ins, input logic z, input logic c,
                           input logic [10:0] sa, input logic rdy, input string name);
    out_t e;
    instruction = ins; zero = z; carry = c; stack_addr = sa; io_ready = rdy;
    #1;
    total_cnt++;
    if (obs !== '0) $display("FAIL %s fetch: got %h want 0", name, obs);
    else pass_cnt++;
    @(posedge clk); @(negedge clk); #1;
    total_cnt++;
    if (obs !== '0) $display("FAIL %s decode: got %h want 0", name, obs);
    else pass_cnt++;
    @(posedge clk); @(negedge clk); #1;
    e = model(ins, z, c, sa, rdy);
    total_cnt++;
    if (obs !== e) $display("FAIL %s exec ins=%h: got %h want %h", name, ins, obs, e);
    else pass_cnt++;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    total_cnt++;
    if (obs !== '0) $display("FAIL reset_state: got %h want 0", obs);
    else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    instruction = 16'h4A20;
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    total_cnt++;
    if (obs.we !== 1'b1) $display("FAIL reset_pre_exec we: got %b want 1", obs.we);
    else pass_cnt++;
    rst = 1'b0; #1;
    total_cnt++;
    if (obs !== '0) $display("FAIL reset_async: got %h want 0", obs);
    else pass_cnt++;
    @(negedge clk); rst = 1'b1; #1;
    total_cnt++;
    if (obs.ldpc !== 1'b0) $display("FAIL reset_first_fetch ldpc: got %b want 0", obs.ldpc);
    else pass_cnt++;
    run_instr(16'h0000, 1'b0, 1'b0, 11'h0, 1'b1, "nop_after_reset");
  endtask

  task automatic test_directed;
    run_instr(16'h0B5A, 1'b0, 1'b0, 11'h0,   1'b1, "ldi");
    run_instr(16'h8A0F, 1'b0, 1'b0, 11'h0,   1'b1, "alu_imm");
    run_instr(16'h4B60, 1'b1, 1'b1, 11'h0,   1'b1, "alu_reg");
    run_instr(16'hC305, 1'b0, 1'b0, 11'h0,   1'b1, "shift");
    run_instr(16'hD123, 1'b1, 1'b0, 11'h0,   1'b1, "jz_taken");
    run_instr(16'hD123, 1'b0, 1'b1, 11'h0,   1'b1, "jz_not_taken");
    run_instr(16'hD923, 1'b0, 1'b1, 11'h0,   1'b1, "jc_taken");
    run_instr(16'hD923, 1'b1, 1'b0, 11'h0,   1'b1, "jc_not_taken");
    run_instr(16'hE040, 1'b0, 1'b0, 11'h0,   1'b1, "call");
    run_instr(16'hE800, 1'b0, 1'b0, 11'h011, 1'b1, "ret");
    run_instr(16'h1120, 1'b0, 1'b0, 11'h0,   1'b1, "in");
    run_instr(16'h1D33, 1'b0, 1'b0, 11'h0,   1'b1, "out");
    run_instr(16'hFFFF, 1'b0, 1'b0, 11'h0,   1'b1, "nop_11111");
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ins;
      logic        rdy;
      ins = 16'($urandom);
      if (ins[15:11] == 5'b11110) ins[15:11] = 5'b00000;
`ifdef CU_IO_WAIT_EN
      rdy = 1'b1;
`else
      rdy = 1'($urandom);
`endif
      run_instr(ins, 1'($urandom), 1'($urandom), 11'($urandom), rdy, "random");
    end
  endtask

  task automatic test_io_wait;
`ifdef CU_IO_WAIT_EN
    instruction = 16'h1120; io_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      io_ready = (i == 4); #1;
      total_cnt++;
      if (obs.rd_strobe !== 1'b1 || obs.we !== (i == 4) || obs.ldpc !== (i == 4))
        $display("FAIL io_wait cycle %0d: strobe=%b we=%b ldpc=%b want 1/%b/%b",
                 i, obs.rd_strobe, obs.we, obs.ldpc, (i == 4), (i == 4));
      else pass_cnt++;
    end
    @(negedge clk); #1;
    total_cnt++;
    if (obs !== '0) $display("FAIL io_wait_done fetch: got %h want 0", obs);
    else pass_cnt++;
    io_ready = 1'b1;
    @(negedge clk);
`endif
  endtask

  task automatic test_halt;
    out_t h;
    h = '0; h.halted = 1'b1;
    run_instr(16'hF000, 1'b0, 1'b0, 11'h0, 1'b1, "halt_exec");
    for (int i = 0; i < 6; i++) begin
      instruction = 16'($urandom);
      #1;
      total_cnt++;
      if (obs !== h) $display("FAIL halt_hold cycle %0d: got %h want %h", i, obs, h);
      else pass_cnt++;
      @(negedge clk);
    end
    rst = 1'b0; #1;
    total_cnt++;
    if (obs !== '0) $display("FAIL halt_reset_exit: got %h want 0", obs);
    else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    run_instr(16'h0B5A, 1'b0, 1'b0, 11'h0, 1'b1, "ldi_after_halt");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_io_wait();
    test_halt();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
